// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the score_keeper game bookkeeping block.
package score_pkg;

    typedef enum logic [1:0] {
        AWARD_10   = 2'd0,
        AWARD_100  = 2'd1,
        AWARD_200  = 2'd2,
        AWARD_1000 = 2'd3
    } award_code_t;

    // Packed BCD addend for each award code; entry 0 is the +0010 award.
    localparam logic [3:0][15:0] AWARD_TABLE = {16'h1000, 16'h0200, 16'h0100, 16'h0010};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADD    = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [15:0] BCD_MAX4 = 16'h9999;
    localparam logic [7:0]  BCD_MAX2 = 8'h99;

    function automatic logic [15:0] award_addend(input award_code_t code);
        return AWARD_TABLE[code];
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Event inputs and display-value outputs of the score_keeper block.
interface score_keeper_if;

    logic        Clear;
    logic        Pause;
    logic        Award_Valid;
    logic [1:0]  Award_Code;
    logic        Award_Ready;
    logic        Coin_Evt;
    logic        Life_Lost;
    logic [15:0] Score;
    logic [7:0]  Coins;
    logic [3:0]  Lives;
    logic        One_Up;
    logic        Game_Over;

    modport master (
        output Clear, Pause, Award_Valid, Award_Code, Coin_Evt, Life_Lost,
        input  Award_Ready, Score, Coins, Lives, One_Up, Game_Over
    );

    modport slave (
        input  Clear, Pause, Award_Valid, Award_Code, Coin_Evt, Life_Lost,
        output Award_Ready, Score, Coins, Lives, One_Up, Game_Over
    );

endinterface

// File: rtl/score_keeper_bcd_digit_add.sv
// Single BCD digit adder: s = a + b + cin, folded back into 0..9 with a carry.
module bcd_digit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] raw;
    logic [4:0] adjusted;

    // Binary sum first, then subtract ten when it leaves the decimal digit range.
    always_comb begin
        raw      = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        adjusted = raw - 5'd10;
        if (raw > 5'd9) begin
            s    = adjusted[3:0];
            cout = 1'b1;
        end else begin
            s    = raw[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Game-state bookkeeping: BCD score via digit-serial adder, BCD coins, lives, game over.
module score_keeper
    import score_pkg::*;
#(
    parameter int unsigned LIVES_INIT = 3,
    parameter int unsigned LIVES_MAX  = 9
) (
    input  logic           Clk,
    input  logic           Reset,
    score_keeper_if.slave  bus
);

    localparam logic [3:0] LIVES_INIT_V = 4'(LIVES_INIT);
    localparam logic [3:0] LIVES_MAX_V  = 4'(LIVES_MAX);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        carry_q, carry_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] addend_q, addend_d;
    logic [15:0] score_q, score_d;
    logic        ready;

    logic [3:0]  digitA, digitB, digitS;
    logic        digitCout;

    logic [7:0]  coins_q, coins_d;
    logic        oneUp_q, oneUp_d;
    logic [3:0]  lives_q, lives_d;
    logic        gameOver_q, gameOver_d;
    logic        lifeDown;

    logic [3:0]  coinLo, coinHi;
    logic        coinLoCout, coinHiCout;

    assign digitA = shadow_q[{idx_q, 2'b00} +: 4];
    assign digitB = addend_q[{idx_q, 2'b00} +: 4];

    bcd_digit_add u_score_digit (
        .a    (digitA),
        .b    (digitB),
        .cin  (carry_q),
        .s    (digitS),
        .cout (digitCout)
    );

    bcd_digit_add u_coin_lo (
        .a    (coins_q[3:0]),
        .b    (4'd0),
        .cin  (1'b1),
        .s    (coinLo),
        .cout (coinLoCout)
    );

    bcd_digit_add u_coin_hi (
        .a    (coins_q[7:4]),
        .b    (4'd0),
        .cin  (coinLoCout),
        .s    (coinHi),
        .cout (coinHiCout)
    );

    // Score FSM: accept an award, add it one digit per cycle into the shadow, then commit or saturate.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        shadow_d = shadow_q;
        addend_d = addend_q;
        score_d  = score_q;
        ready    = 1'b0;

        case (state_q)
            IDLE: begin
                ready = !bus.Pause;
                if (bus.Award_Valid && ready) begin
                    shadow_d = score_q;
                    addend_d = award_addend(award_code_t'(bus.Award_Code));
                    carry_d  = 1'b0;
                    idx_d    = 2'd0;
                    state_d  = ADD;
                end
            end
            ADD: begin
                shadow_d[{idx_q, 2'b00} +: 4] = digitS;
                carry_d = digitCout;
                idx_d   = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                score_d = carry_q ? BCD_MAX4 : shadow_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.Clear) begin
            state_d  = IDLE;
            idx_d    = 2'd0;
            carry_d  = 1'b0;
            shadow_d = 16'h0000;
            addend_d = 16'h0000;
            score_d  = 16'h0000;
        end
    end

    // Score FSM registers; an abandoned award never reaches score_q.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            carry_q  <= 1'b0;
            shadow_q <= 16'h0000;
            addend_q <= 16'h0000;
            score_q  <= 16'h0000;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            shadow_q <= shadow_d;
            addend_q <= addend_d;
            score_q  <= score_d;
        end
    end

    // Coin count, extra-life pulse, lives up/down with saturation, and sticky game over.
    always_comb begin
        coins_d    = coins_q;
        oneUp_d    = 1'b0;
        lives_d    = lives_q;
        gameOver_d = gameOver_q | (lives_q == 4'd0);
        lifeDown   = bus.Life_Lost && !bus.Pause;

        if (bus.Coin_Evt && !bus.Pause) begin
            coins_d = {coinHi, coinLo};
            oneUp_d = coinHiCout;
        end

        if (oneUp_q && !lifeDown) begin
            if (lives_q < LIVES_MAX_V) begin
                lives_d = lives_q + 4'd1;
            end
        end else if (!oneUp_q && lifeDown) begin
            if (lives_q != 4'd0) begin
                lives_d = lives_q - 4'd1;
            end
        end

        if (bus.Clear) begin
            coins_d    = 8'h00;
            oneUp_d    = 1'b0;
            lives_d    = LIVES_INIT_V;
            gameOver_d = (LIVES_INIT_V == 4'd0);
        end
    end

    // Coin and lives registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            coins_q    <= 8'h00;
            oneUp_q    <= 1'b0;
            lives_q    <= LIVES_INIT_V;
            gameOver_q <= (LIVES_INIT_V == 4'd0);
        end else begin
            coins_q    <= coins_d;
            oneUp_q    <= oneUp_d;
            lives_q    <= lives_d;
            gameOver_q <= gameOver_d;
        end
    end

    assign bus.Award_Ready = ready;
    assign bus.Score       = score_q;
    assign bus.Coins       = coins_q;
    assign bus.Lives       = lives_q;
    assign bus.One_Up      = oneUp_q;
    assign bus.Game_Over   = gameOver_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper.
module tb_score_keeper;

    logic Clk;
    logic Reset;
    int   checks;
    int   errors;
    int   modelScore;

    score_keeper_if bus();

    score_keeper #(
        .LIVES_INIT (3),
        .LIVES_MAX  (9)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Hard stop in case the DUT never releases the bench.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] code, input logic coin,
                                 input logic life, input logic pause, input logic clear);
        bus.Award_Valid = valid;
        bus.Award_Code  = code;
        bus.Coin_Evt    = coin;
        bus.Life_Lost   = life;
        bus.Pause       = pause;
        bus.Clear       = clear;
    endtask

    function automatic logic [15:0] toBcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int awardValue(input logic [1:0] code);
        case (code)
            2'd0:    return 10;
            2'd1:    return 100;
            2'd2:    return 200;
            default: return 1000;
        endcase
    endfunction

    task automatic doClear();
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        modelScore = 0;
    endtask

    task automatic runAward(input logic [1:0] code, input string tag);
        int waitCnt;
        int lowCnt;
        logic [15:0] scoreAt4;
        logic [15:0] oldScore;
        waitCnt  = 0;
        lowCnt   = 0;
        scoreAt4 = 16'hxxxx;
        while (bus.Award_Ready !== 1'b1 && waitCnt < 20) begin
            tick();
            waitCnt++;
        end
        checkOutput({tag, " ready_before"}, 32'(bus.Award_Ready), 32'd1);
        oldScore = toBcd(modelScore);
        applyStimulus(1'b1, code, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        while (bus.Award_Ready !== 1'b1 && lowCnt < 20) begin
            tick();
            lowCnt++;
            if (lowCnt == 4) scoreAt4 = bus.Score;
        end
        modelScore = modelScore + awardValue(code);
        if (modelScore > 9999) modelScore = 9999;
        checkOutput({tag, " ready_low_cycles"}, 32'(lowCnt), 32'd5);
        checkOutput({tag, " score_before_commit"}, 32'(scoreAt4), 32'(oldScore));
        checkOutput({tag, " score"}, 32'(bus.Score), 32'(toBcd(modelScore)));
    endtask

    // Linear sequence of directed steps.
    initial begin
        checks     = 0;
        errors     = 0;
        modelScore = 0;
        Reset      = 1'b0;
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        #12;
        checkOutput("rst score", 32'(bus.Score), 32'h0000);
        checkOutput("rst coins", 32'(bus.Coins), 32'h00);
        checkOutput("rst lives", 32'(bus.Lives), 32'd3);
        checkOutput("rst one_up", 32'(bus.One_Up), 32'd0);
        checkOutput("rst game_over", 32'(bus.Game_Over), 32'd0);
        checkOutput("rst ready", 32'(bus.Award_Ready), 32'd1);
        #10 Reset = 1'b1;
        tick();

        $display("[TB] score awards and saturation");
        repeat (9) runAward(2'd3, "k1000");
        repeat (4) runAward(2'd2, "k200");
        runAward(2'd1, "k100");
        repeat (5) runAward(2'd0, "k10");
        checkOutput("score 9950", 32'(bus.Score), 32'h9950);
        runAward(2'd1, "sat");
        checkOutput("sat 9999", 32'(bus.Score), 32'h9999);
        runAward(2'd0, "sat_hold");
        checkOutput("sat hold 9999", 32'(bus.Score), 32'h9999);

        $display("[TB] carry ripple");
        doClear();
        checkOutput("clear score", 32'(bus.Score), 32'h0000);
        repeat (9) runAward(2'd0, "to90");
        runAward(2'd0, "ripple2");
        checkOutput("ripple2 0100", 32'(bus.Score), 32'h0100);
        repeat (4) runAward(2'd2, "to900");
        repeat (9) runAward(2'd0, "to990");
        runAward(2'd0, "ripple3");
        checkOutput("ripple3 1000", 32'(bus.Score), 32'h1000);

        $display("[TB] coins and extra lives");
        doClear();
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (98) tick();
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("coins 98", 32'(bus.Coins), 32'h98);
        bus.Coin_Evt = 1'b1; tick(); bus.Coin_Evt = 1'b0;
        checkOutput("coins 99", 32'(bus.Coins), 32'h99);
        checkOutput("one_up idle", 32'(bus.One_Up), 32'd0);
        bus.Coin_Evt = 1'b1; tick(); bus.Coin_Evt = 1'b0;
        checkOutput("coins wrap", 32'(bus.Coins), 32'h00);
        checkOutput("one_up pulse", 32'(bus.One_Up), 32'd1);
        checkOutput("lives not yet", 32'(bus.Lives), 32'd3);
        tick();
        checkOutput("one_up one cycle", 32'(bus.One_Up), 32'd0);
        checkOutput("lives 4", 32'(bus.Lives), 32'd4);
        bus.Coin_Evt = 1'b1; repeat (500) tick(); bus.Coin_Evt = 1'b0;
        tick();
        checkOutput("lives 9", 32'(bus.Lives), 32'd9);
        bus.Coin_Evt = 1'b1; repeat (100) tick(); bus.Coin_Evt = 1'b0;
        tick();
        checkOutput("lives sat 9", 32'(bus.Lives), 32'd9);
        checkOutput("coins after wraps", 32'(bus.Coins), 32'h00);

        $display("[TB] lives lost and game over");
        doClear();
        checkOutput("clear lives", 32'(bus.Lives), 32'd3);
        bus.Life_Lost = 1'b1; repeat (2) tick(); bus.Life_Lost = 1'b0;
        checkOutput("lives 1", 32'(bus.Lives), 32'd1);
        bus.Life_Lost = 1'b1; tick(); bus.Life_Lost = 1'b0;
        checkOutput("lives 0", 32'(bus.Lives), 32'd0);
        checkOutput("game_over lag", 32'(bus.Game_Over), 32'd0);
        tick();
        checkOutput("game_over set", 32'(bus.Game_Over), 32'd1);
        bus.Life_Lost = 1'b1; tick(); bus.Life_Lost = 1'b0;
        checkOutput("lives floor", 32'(bus.Lives), 32'd0);
        bus.Coin_Evt = 1'b1; tick(); bus.Coin_Evt = 1'b0;
        checkOutput("coin after game_over", 32'(bus.Coins), 32'h01);
        checkOutput("game_over held", 32'(bus.Game_Over), 32'd1);

        $display("[TB] one-up and life lost together");
        doClear();
        checkOutput("clear game_over", 32'(bus.Game_Over), 32'd0);
        bus.Coin_Evt = 1'b1; repeat (99) tick(); bus.Coin_Evt = 1'b0;
        bus.Coin_Evt = 1'b1; tick(); bus.Coin_Evt = 1'b0;
        checkOutput("same one_up", 32'(bus.One_Up), 32'd1);
        bus.Life_Lost = 1'b1; tick(); bus.Life_Lost = 1'b0;
        checkOutput("same cycle lives", 32'(bus.Lives), 32'd3);
        tick();
        checkOutput("same cycle lives later", 32'(bus.Lives), 32'd3);

        $display("[TB] clear during award");
        doClear();
        runAward(2'd3, "pre_clear");
        applyStimulus(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        bus.Clear = 1'b1; tick(); bus.Clear = 1'b0;
        modelScore = 0;
        checkOutput("clear mid score", 32'(bus.Score), 32'h0000);
        checkOutput("clear mid ready", 32'(bus.Award_Ready), 32'd1);
        repeat (6) tick();
        checkOutput("clear mid no commit", 32'(bus.Score), 32'h0000);

        $display("[TB] pause during award");
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        bus.Coin_Evt = 1'b0;
        tick();
        tick();
        checkOutput("pause pre commit", 32'(bus.Score), 32'h0000);
        tick();
        checkOutput("pause commit", 32'(bus.Score), 32'h0100);
        checkOutput("pause ready low", 32'(bus.Award_Ready), 32'd0);
        repeat (3) tick();
        checkOutput("pause ready still low", 32'(bus.Award_Ready), 32'd0);
        checkOutput("pause coin ignored", 32'(bus.Coins), 32'h00);
        bus.Pause = 1'b0;
        #1;
        checkOutput("unpause ready", 32'(bus.Award_Ready), 32'd1);

        $display("[TB] asynchronous reset during award");
        tick();
        bus.Coin_Evt = 1'b1; tick(); bus.Coin_Evt = 1'b0;
        checkOutput("coin before reset", 32'(bus.Coins), 32'h01);
        applyStimulus(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        #2 Reset = 1'b0;
        #1;
        checkOutput("async rst score", 32'(bus.Score), 32'h0000);
        checkOutput("async rst coins", 32'(bus.Coins), 32'h00);
        checkOutput("async rst ready", 32'(bus.Award_Ready), 32'd1);
        #2 Reset = 1'b1;
        modelScore = 0;
        tick();
        runAward(2'd0, "post_reset");
        checkOutput("post reset 0010", 32'(bus.Score), 32'h0010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
